fresh_query_sequencer: RTL and testbench
========================================

// Module: fresh_query_sequencer
// PURPOSE
// - Sequences ingredient-ID lookups against the fresh-ingredient datapath once ranges are loaded.
// - Accepts a batch of IDs (valid/ready), drives check_addr only while check_ready is high, and realigns out_fresh with each ID.
// - Emits a backpressurable result stream plus the batch's fresh count. Sits between the puzzle-input parser and the fresh datapath, on its clk.
// PARAMETERS
// - ADDR_W     17   ID / RAM address width; must match the datapath.
// - RD_LAT     3    cycles from ID handshake to the matching out_fresh sample (issue reg + BRAM reg + out reg).
// - FIFO_DEPTH 4    result FIFO entries; power of two, >= RD_LAT+1 for full throughput.
// - CNT_W      ADDR_W+1  fresh counter width.
// PORTS
// - clk          in   1        datapath clock
// - rst          in   1        synchronous, active-high reset
// - id_valid     in   1        ID offered
// - id_ready     out  1        ID accepted when id_valid & id_ready
// - id_addr      in   ADDR_W   ingredient ID
// - id_last      in   1        marks final ID of batch
// - check_addr   out  ADDR_W   registered lookup address to datapath
// - check_ready  in   1        datapath RAM consistent (no range load pending)
// - out_fresh    in   1        datapath lookup result, RD_LAT after handshake
// - res_valid    out  1        result available
// - res_ready    in   1        consumer accepts result
// - res_addr     out  ADDR_W   ID of this result
// - res_fresh    out  1        1 = ID inside a fresh range
// - res_last     out  1        result of batch's last ID
// - fresh_count  out  CNT_W    fresh IDs in current batch, saturating
// - count_valid  out  1        fresh_count final for batch
// - busy         out  1        lookups in flight or results unread
// BEHAVIOUR
// - Reset: id_ready=0 in reset cycle, check_addr=0, res_valid=0, fresh_count=0, count_valid=0, busy=0; in-flight pipe and FIFO cleared, no result emitted for pre-reset IDs.
// - States: IDLE, RUN, DRAIN. IDLE->RUN on first handshake; RUN->DRAIN on handshake with id_last; DRAIN->IDLE when last result written to FIFO.
// - id_ready = check_ready & (state!=DRAIN) & (inflight + fifo_count < FIFO_DEPTH); combinational, no dependence on id_valid.
// - Issue: on handshake at cycle T, check_addr<=id_addr at T+1; {addr,last} enters a RD_LAT-deep valid shift pipe.
// - Capture: at pipe output (cycle T+RD_LAT) push {addr, out_fresh, last} into FIFO; credit scheme guarantees FIFO never overflows, push is never dropped.
// - check_ready falling stalls new issues only; in-flight lookups complete (datapath guarantees >=2 cycles before first RAM write).
// - check_addr holds its last value when idle.
// - Count: first handshake in IDLE clears fresh_count and count_valid; each push with out_fresh=1 increments, saturating at all-ones.
// - count_valid rises the cycle after the last-tagged push; holds with stable fresh_count until next batch's first handshake or rst.
// - Result FIFO: first-word-fall-through; res_* valid combinationally from head; pop on res_valid & res_ready; simultaneous push+pop at full/empty allowed, occupancy unchanged.
// - Throughput: one ID per cycle when res_ready=1 and check_ready=1.
// - busy = (state!=IDLE) | res_valid.
// - Batch of one ID (id_last on first): IDLE->RUN->DRAIN in the same handshake, i.e. direct IDLE->DRAIN.
// STRUCTURE
// - fresh_pkg: ADDR_W default, RD_LAT default, state encoding constants (IDLE/RUN/DRAIN), result record width.
// - Sub-module fresh_result_fifo: synchronous FWFT FIFO, width ADDR_W+2, depth FIFO_DEPTH, count output for credit logic.
// - Top holds FSM, issue register, latency pipe, credit counter, fresh counter.
// TESTING
// - Datapath model with ranges 3..5 and 10..14 fresh; IDs 1,5,8,11,17,32 (last on 32), res_ready=1 -> results 0,1,0,1,0,1? no: 32 spoiled -> 0,1,0,1,0,0; fresh_count=2, count_valid one cycle after last push.
// - Back-to-back 16 IDs, res_ready=1, check_ready=1 -> id_ready never drops, first result at cycle RD_LAT after first handshake, one result/cycle.
// - res_ready=0 throughout -> exactly FIFO_DEPTH IDs accepted, then id_ready=0; raise res_ready -> results in order, no loss or duplication.
// - check_ready dropped for 5 cycles mid-batch -> no handshake while low, in-flight results still correct, stream resumes in order.
// - 2^CNT_W+3 fresh IDs (reduced CNT_W=3) -> fresh_count saturates at 7.
// - rst asserted with 2 lookups in flight and 2 results queued -> next cycle res_valid=0, count 0, no stale result after release; new single-ID batch completes normally.

Source files
------------

// File: rtl/fresh_pkg.sv
// Shared defaults and types for the fresh-ingredient query sequencer.
// The result record is {addr, fresh, last}.
package fresh_pkg;

    localparam int unsigned ADDR_W_DEF     = 17;
    localparam int unsigned RD_LAT_DEF     = 3;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    function automatic int unsigned result_w(input int unsigned addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/fresh_result_fifo.sv
// First-word-fall-through result FIFO; head and not_empty come straight from storage.
// Exposes its occupancy so the sequencer can run its credit check.
module fresh_result_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (count != '0);
    assign do_pop    = pop & not_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push   = push & ((count != CNT_FULL) | do_pop);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fresh_query_sequencer.sv
// Issues ingredient-ID lookups to the fresh datapath, realigns out_fresh with each ID
// and queues {addr, fresh, last} results while counting fresh IDs per batch.
module fresh_query_sequencer
    import fresh_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned RD_LAT     = RD_LAT_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned CNT_W      = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_addr,
    input  logic              id_last,
    output logic [ADDR_W-1:0] check_addr,
    input  logic              check_ready,
    input  logic              out_fresh,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic              res_fresh,
    output logic              res_last,
    output logic [CNT_W-1:0]  fresh_count,
    output logic              count_valid,
    output logic              busy
);

    localparam int unsigned REC_W = result_w(ADDR_W);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    seq_state_t        state;
    seq_state_t        state_nx;
    logic              hs;
    logic              push;
    logic              push_last;
    logic              pop;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_last;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [REC_W-1:0]  push_data;
    logic [REC_W-1:0]  head;
    logic [CW-1:0]     fifo_count;
    int unsigned       credit;

    assign hs        = id_valid & id_ready;
    assign push      = pipe_v[RD_LAT-1];
    assign push_last = pipe_last[RD_LAT-1];
    assign push_data = {pipe_addr[RD_LAT-1], out_fresh, push_last};
    assign pop       = res_valid & res_ready;
    assign {res_addr, res_fresh, res_last} = head;

    // Every accepted-but-unconsumed ID holds a FIFO slot; a pop this cycle frees
    // its slot at once so the pipe can stay full at one ID per cycle.
    always_comb begin
        credit = 32'(fifo_count) - 32'(pop);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            credit = credit + 32'(pipe_v[i]);
        end
    end

    assign id_ready = ~rst & check_ready & (state != ST_DRAIN) & (credit < FIFO_DEPTH);
    assign busy     = (state != ST_IDLE) | res_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v     <= '0;
            check_addr <= '0;
        end else begin
            pipe_v[0] <= hs;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
            end
            if (hs) begin
                check_addr <= id_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr[0] <= id_addr;
        pipe_last[0] <= id_last;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_last[i] <= pipe_last[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nx = id_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (hs && id_last) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (push && push_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // No push can be pending while IDLE, so the batch clear never races an increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_count <= '0;
            count_valid <= 1'b0;
        end else if (hs && (state == ST_IDLE)) begin
            fresh_count <= '0;
            count_valid <= 1'b0;
        end else begin
            if (push && out_fresh && (fresh_count != '1)) begin
                fresh_count <= fresh_count + CNT_W'(1);
            end
            if (push && push_last) begin
                count_valid <= 1'b1;
            end
        end
    end

    fresh_result_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .not_empty (res_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fresh_query_sequencer.sv
// Bench for fresh_query_sequencer: datapath model with fresh ranges 3..5 and 10..14,
// queue-based result/count scoreboard, directed corner cases and a randomized phase.
module tb_fresh_query_sequencer;

    localparam int ADDR_W = 17;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk         = 1'b0;
    logic              rst         = 1'b1;
    logic              id_valid    = 1'b0;
    logic [ADDR_W-1:0] id_addr     = '0;
    logic              id_last     = 1'b0;
    logic              check_ready = 1'b1;
    logic              out_fresh   = 1'b0;
    logic              res_ready   = 1'b1;
    logic              id_ready;
    logic [ADDR_W-1:0] check_addr;
    logic              res_valid;
    logic [ADDR_W-1:0] res_addr;
    logic              res_fresh;
    logic              res_last;
    logic [CNT_W-1:0]  fresh_count;
    logic              count_valid;
    logic              busy;

    always #5 clk = ~clk;

    fresh_query_sequencer #(
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_addr     (id_addr),
        .id_last     (id_last),
        .check_addr  (check_addr),
        .check_ready (check_ready),
        .out_fresh   (out_fresh),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_addr    (res_addr),
        .res_fresh   (res_fresh),
        .res_last    (res_last),
        .fresh_count (fresh_count),
        .count_valid (count_valid),
        .busy        (busy)
    );

    function automatic logic is_fresh(input logic [ADDR_W-1:0] a);
        return (a >= 3 && a <= 5) || (a >= 10 && a <= 14);
    endfunction

    // Datapath: BRAM register then output register behind the registered check_addr.
    logic bram_q = 1'b0;
    always @(posedge clk) begin
        bram_q    <= is_fresh(check_addr);
        out_fresh <= bram_q;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              fresh;
        logic              last;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    int   fin_q[$];
    int   batch_cnt   = 0;
    bit   in_batch    = 0;
    int   outstanding = 0;
    int   cyc         = 0;
    int   hs_n        = 0;
    int   stall_n     = 0;
    int   first_hs    = -1;
    int   first_res   = -1;
    int   pop_first   = -1;
    int   pop_last    = -1;
    int   pop_n       = 0;
    bit   cv_prev     = 0;
    int   held_exp    = 0;
    bit   m_hs;
    bit   m_pp;
    res_t m_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            fin_q.delete();
            in_batch    = 0;
            batch_cnt   = 0;
            outstanding = 0;
            cv_prev     = 0;
        end else begin
            m_hs = id_valid && id_ready;
            m_pp = res_valid && res_ready;
            if (id_valid && !id_ready) stall_n++;
            if (!check_ready) check("ready_gated", id_ready, 0);
            if (res_valid && first_res < 0) first_res = cyc;
            if (m_hs) begin
                check("credit_bound", (outstanding - int'(m_pp)) < DEPTH, 1);
                if (!in_batch) begin
                    batch_cnt = 0;
                    in_batch  = 1;
                end
                if (is_fresh(id_addr) && batch_cnt < SAT) batch_cnt++;
                exp_q.push_back('{id_addr, is_fresh(id_addr), id_last});
                if (id_last) begin
                    fin_q.push_back(batch_cnt);
                    in_batch = 0;
                end
                if (first_hs < 0) first_hs = cyc + 1;
                hs_n++;
                outstanding++;
            end
            if (m_pp) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got addr %0d expected no result", res_addr);
                end else begin
                    m_e = exp_q.pop_front();
                    check("res_addr", res_addr, m_e.addr);
                    check("res_fresh", res_fresh, m_e.fresh);
                    check("res_last", res_last, m_e.last);
                end
                got_q.push_back('{res_addr, res_fresh, res_last});
                if (pop_first < 0) pop_first = cyc;
                pop_last = cyc;
                pop_n++;
                outstanding--;
            end
            if (count_valid && !cv_prev) begin
                if (fin_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL count_valid_spurious: got count_valid 1 expected 0");
                end else begin
                    held_exp = fin_q.pop_front();
                    check("batch_count", fresh_count, held_exp);
                end
            end else if (count_valid && cv_prev) begin
                check("count_hold", fresh_count, held_exp);
            end
            cv_prev = count_valid;
        end
    end

    task automatic send(input logic [ADDR_W-1:0] a, input logic l);
        int w;
        w        = 0;
        id_valid = 1'b1;
        id_addr  = a;
        id_last  = l;
        @(negedge clk);
        while (!id_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!id_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got id_ready 0 expected 1 for addr %0d", a);
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        id_last  = 1'b0;
    endtask

    bit stream_done = 0;
    task automatic stream(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) send(ADDR_W'(base + i * step), i == n - 1);
        stream_done = 1;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!stream_done && w < 2000) begin
            w++;
            @(posedge clk);
        end
        if (!stream_done) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got done 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 400) begin
            w++;
            @(negedge clk);
        end
        check("idle_reached", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_stats();
        first_hs  = -1;
        first_res = -1;
        pop_first = -1;
        pop_last  = -1;
        pop_n     = 0;
        hs_n      = 0;
        stall_n   = 0;
        got_q.delete();
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic              exp_fresh;
    } vec_t;

    vec_t vt[6];
    bit   rand_on = 0;
    int   hs_before;
    int   len;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{ADDR_W'(1),  1'b0, 1'b0};
        vt[1] = '{ADDR_W'(5),  1'b0, 1'b1};
        vt[2] = '{ADDR_W'(8),  1'b0, 1'b0};
        vt[3] = '{ADDR_W'(11), 1'b0, 1'b1};
        vt[4] = '{ADDR_W'(17), 1'b0, 1'b0};
        vt[5] = '{ADDR_W'(32), 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_id_ready", id_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fresh_count, 0);
        check("rst_count_valid", count_valid, 0);
        check("rst_check_addr", check_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", id_ready, 1);
        @(posedge clk);
        #1;

        // Table-driven batch: IDs 1,5,8,11,17,32
        reset_stats();
        for (int i = 0; i < 5; i++) send(vt[i].addr, vt[i].last);
        send(vt[5].addr, vt[5].last);
        repeat (2) @(posedge clk);
        #1;
        check("t1_cv_early", count_valid, 0);
        @(posedge clk);
        #1;
        check("t1_cv_rise", count_valid, 1);
        check("t1_count", fresh_count, 2);
        wait_idle();
        check("t1_size", got_q.size(), 6);
        if (got_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_addr", got_q[i].addr, vt[i].addr);
                check("t1_fresh", got_q[i].fresh, vt[i].exp_fresh);
                check("t1_last", got_q[i].last, vt[i].last);
            end
        end

        // Back-to-back 16 IDs at full rate
        reset_stats();
        for (int i = 0; i < 16; i++) send(ADDR_W'(i), i == 15);
        wait_idle();
        check("b2b_stalls", stall_n, 0);
        check("b2b_latency", first_res - first_hs, RD_LAT);
        check("b2b_pops", pop_n, 16);
        check("b2b_spacing", pop_last - pop_first, 15);
        check("b2b_sat_count", fresh_count, SAT);

        // Consumer stalled: only DEPTH IDs may be accepted
        reset_stats();
        res_ready   = 1'b0;
        stream_done = 0;
        fork
            stream(6, 2, 2);
        join_none
        repeat (12) @(posedge clk);
        #1;
        check("bp_accepted", hs_n, DEPTH);
        check("bp_id_ready", id_ready, 0);
        check("bp_res_valid", res_valid, 1);
        res_ready = 1'b1;
        wait_done();
        wait_idle();
        check("bp_pops", pop_n, 6);

        // check_ready low for 5 cycles mid-batch
        reset_stats();
        stream_done = 0;
        fork
            stream(12, 1, 1);
        join_none
        repeat (4) @(posedge clk);
        #1;
        check_ready = 1'b0;
        hs_before   = hs_n;
        repeat (5) @(posedge clk);
        #1;
        check("cr_no_hs", hs_n, hs_before);
        check_ready = 1'b1;
        wait_done();
        wait_idle();
        check("cr_pops", pop_n, 12);

        // Saturation: 11 fresh IDs with a 3-bit counter
        stream_done = 0;
        stream(11, 3, 0);
        wait_idle();
        check("sat_count", fresh_count, SAT);

        // Reset with lookups in flight and results queued
        reset_stats();
        res_ready = 1'b0;
        send(ADDR_W'(12), 1'b0);
        send(ADDR_W'(3), 1'b0);
        send(ADDR_W'(7), 1'b0);
        send(ADDR_W'(10), 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_queued", res_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_id_ready", id_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_count", fresh_count, 0);
        check("mid_rst_cv", count_valid, 0);
        check("mid_rst_busy", busy, 0);
        rst       = 1'b0;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("no_stale", res_valid, 0);
        send(ADDR_W'(11), 1'b1);
        wait_idle();
        check("single_count", fresh_count, 1);
        check("single_cv", count_valid, 1);
        check("single_pops", pop_n, 1);

        // Randomized batches with random consumer and datapath stalls
        rand_on = 1;
        fork
            while (rand_on) begin
                @(posedge clk);
                #1;
                res_ready   = ($urandom_range(0, 3) != 0);
                check_ready = ($urandom_range(0, 7) != 0);
            end
        join_none
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) send(ADDR_W'($urandom_range(0, 40)), i == len - 1);
        end
        rand_on = 0;
        @(posedge clk);
        #2;
        res_ready   = 1'b1;
        check_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("sb_results_left", exp_q.size(), 0);
        check("sb_counts_left", fin_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
